// File: rtl/tbus_arb_pkg.sv
// Shared types and helpers for the tristate bus arbiter: FSM state encoding,
// index/counter widths and a one-hot decoder.
package tbus_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int OWNER_W = $clog2(MAX_REQ);
  localparam int CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } arb_state_e;

  function automatic logic [MAX_REQ-1:0] onehot_of(input logic [OWNER_W-1:0] idx);
    logic [MAX_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/tristate_bus_arbiter_picker.sv
// Round-robin winner selection: first set request at or above the pointer,
// wrapping from the top index back to zero. Purely combinational.
module rr_priority_picker #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [$clog2(N_REQ)-1:0] winner,
  output logic                     valid
);

  localparam int W = $clog2(N_REQ);

  // Scan from the farthest offset down so the closest request to ptr wins.
  always_comb begin
    int idx;
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (req[idx]) begin
        winner = W'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter driving one-hot bufif1 bank enables with a dead-bus gap
// between owners. Optional forced release after MAX_HOLD cycles: HOLD_LIMIT_EN.
module tristate_bus_arbiter
  import tbus_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int WIDTH      = 8,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         en,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy
);

  localparam int OW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > MAX_REQ || TURNAROUND < 1 || MAX_HOLD < 1 || WIDTH < 1) begin : g_bad_param
    $error("tristate_bus_arbiter: illegal parameter combination");
  end

  arb_state_e       state;
  logic [N_REQ-1:0] gnt_q;
  logic [OW-1:0]    owner_q;
  logic [OW-1:0]    rr_ptr;
  logic             busy_q;
  logic [CNT_W-1:0] turn_cnt;
  logic [OW-1:0]    pick_idx;
  logic             pick_vld;
  logic             grant_now;
  logic             release_now;
  logic             hold_expired;

  rr_priority_picker #(.N_REQ(N_REQ)) u_picker (
    .req    (req),
    .ptr    (rr_ptr),
    .winner (pick_idx),
    .valid  (pick_vld)
  );

  assign grant_now   = pick_vld && ((state == ST_IDLE) ||
                                    (state == ST_TURN && turn_cnt == '0));
  assign release_now = (state == ST_OWN) && (!req[owner_q] || hold_expired);

`ifdef HOLD_LIMIT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_cnt;

  // Counts completed owned cycles; a fresh grant starts the count at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (grant_now) begin
      hold_cnt <= HOLD_W'(1);
    end else if (state == ST_OWN && !release_now) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign hold_expired = (state == ST_OWN) && (hold_cnt == HOLD_W'(MAX_HOLD));
`else
  assign hold_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      gnt_q    <= '0;
      owner_q  <= '0;
      busy_q   <= 1'b0;
      rr_ptr   <= '0;
      turn_cnt <= '0;
    end else if (grant_now) begin
      state   <= ST_OWN;
      gnt_q   <= N_REQ'(onehot_of(OWNER_W'(pick_idx)));
      owner_q <= pick_idx;
      busy_q  <= 1'b1;
      rr_ptr  <= (pick_idx == OW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end else begin
      case (state)
        ST_OWN: begin
          if (release_now) begin
            state    <= ST_TURN;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            turn_cnt <= CNT_W'(TURNAROUND - 1);
          end
        end
        // turn_cnt reaching zero marks the last dead-bus cycle.
        ST_TURN: begin
          if (turn_cnt != '0) begin
            turn_cnt <= turn_cnt - 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: ;
        default: begin
          state  <= ST_IDLE;
          gnt_q  <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign gnt   = gnt_q;
  assign en    = gnt_q;
  assign owner = owner_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Self-checking bench for tristate_bus_arbiter: directed scenarios plus random
// request traffic, compared every cycle against a behavioural ownership model.
module tb_tristate_bus_arbiter;

  localparam int N_REQ      = 4;
  localparam int TURNAROUND = 1;
  localparam int MAX_HOLD   = 16;
`ifdef HOLD_LIMIT_EN
  localparam bit HOLD_ON = 1'b1;
`else
  localparam bit HOLD_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N_REQ-1:0] req = '0;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] en;
  logic [1:0]       owner;
  logic             busy;

  int checks = 0;
  int failures = 0;

  tristate_bus_arbiter #(
    .N_REQ(N_REQ), .WIDTH(8), .TURNAROUND(TURNAROUND), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .en(en), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the bus, how many dead cycles remain, where
  // the round-robin search starts, and how long the current owner has held.
  int m_owner = -1;
  int m_gap = 0;
  int m_ptr = 0;
  int m_held = 0;
  logic [N_REQ-1:0] prev_en = '0;
  int  zero_run = 0;
  bit  seen_fall = 1'b0;

  always @(posedge clk) begin
    logic [N_REQ-1:0] r;
    logic [N_REQ-1:0] exp_g;
    r = req;
    if (!rst_n) begin
      m_owner = -1; m_gap = 0; m_ptr = 0; m_held = 0;
    end else if (m_owner >= 0) begin
      if (!r[m_owner] || (HOLD_ON && m_held == MAX_HOLD)) begin
        m_owner = -1;
        m_gap   = TURNAROUND;
      end else begin
        m_held++;
      end
    end else begin
      if (m_gap > 0) m_gap--;
      if (m_gap == 0 && r != 0) begin
        for (int k = 0; k < N_REQ; k++) begin
          if (m_owner < 0 && r[(m_ptr + k) % N_REQ]) m_owner = (m_ptr + k) % N_REQ;
        end
        m_ptr  = (m_owner + 1) % N_REQ;
        m_held = 1;
      end
    end
    #1;
    exp_g = (m_owner >= 0) ? N_REQ'(1 << m_owner) : '0;
    chk("gnt", 32'(gnt), 32'(exp_g));
    chk("en", 32'(en), 32'(exp_g));
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    chk("onehot0_en", 32'($onehot0(en)), 32'd1);
    if (m_owner >= 0) chk("owner", 32'(owner), 32'(m_owner));
    if (!rst_n) begin
      chk("owner_reset", 32'(owner), 32'd0);
      seen_fall = 1'b0;
      prev_en   = '0;
    end else begin
      if (en == '0) begin
        if (prev_en != '0) begin
          seen_fall = 1'b1;
          zero_run  = 0;
        end
        zero_run++;
      end else if (prev_en == '0) begin
        if (seen_fall) chk("turn_gap", 32'(zero_run >= TURNAROUND), 32'd1);
      end else begin
        chk("no_direct_swap", 32'(en == prev_en), 32'd1);
      end
      prev_en = en;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int order[$];
    int run_own[$];
    int run_len[$];
    int cnt;
    bit prev_busy;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    // Reset state
    @(negedge clk);
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted mid-ownership, between clock edges
    req = 4'b0001;
    @(negedge clk);
    chk("mid_own_en", 32'(en), 32'h1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_en", 32'(en), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_owner", 32'(owner), 32'd0);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request, then release and return to idle
    req = 4'b0100;
    @(negedge clk);
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_owner", 32'(owner), 32'd2);
    req = '0;
    @(negedge clk);
    chk("single_release_en", 32'(en), 32'd0);
    chk("single_release_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("single_idle_en", 32'(en), 32'd0);

    // Pointer now sits at 3: wrap to 0, then 1
    req = 4'b0011;
    @(negedge clk);
    chk("wrap_owner0", 32'(owner), 32'd0);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    req = 4'b0011;
    @(negedge clk);
    chk("wrap_owner1", 32'(owner), 32'd1);
    req = '0;

    // Round robin with all requesting; each owner drops after 3 cycles
    do_reset();
    req = 4'b1111;
    cnt = 0;
    prev_busy = 1'b0;
    for (int cyc = 0; cyc < 80 && order.size() < 5; cyc++) begin
      @(negedge clk);
      req = 4'b1111;
      if (busy) begin
        if (!prev_busy) begin
          order.push_back(int'(owner));
          cnt = 1;
        end else begin
          cnt++;
        end
        if (cnt == 3) req[owner] = 1'b0;
      end
      prev_busy = busy;
    end
    chk("rr_grants_seen", 32'(order.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i < order.size()) chk("rr_order", 32'(order[i]), 32'(exp_order[i]));
    end

    // Two requesters holding forever
    do_reset();
    req = 4'b0011;
    prev_busy = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (busy) begin
        if (!prev_busy || run_own[run_own.size()-1] != int'(owner)) begin
          run_own.push_back(int'(owner));
          run_len.push_back(1);
        end else begin
          run_len[run_len.size()-1]++;
        end
      end
      prev_busy = busy;
    end
`ifdef HOLD_LIMIT_EN
    chk("hold_runs_seen", 32'(run_own.size() >= 3), 32'd1);
    if (run_own.size() >= 3) begin
      chk("hold_first_owner", 32'(run_own[0]), 32'd0);
      chk("hold_first_len", 32'(run_len[0]), 32'(MAX_HOLD));
      chk("hold_second_owner", 32'(run_own[1]), 32'd1);
      chk("hold_second_len", 32'(run_len[1]), 32'(MAX_HOLD));
    end
`else
    chk("hold_single_run", 32'(run_own.size()), 32'd1);
    chk("hold_still_busy", 32'(busy), 32'd1);
    chk("hold_still_owner0", 32'(owner), 32'd0);
`endif
    req = '0;

    // Random traffic, with one reset in the middle
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc == 1500) begin
        rst_n = 1'b0;
      end else if (cyc == 1502) begin
        rst_n = 1'b1;
      end
      for (int b = 0; b < N_REQ; b++) begin
        if ($urandom_range(0, 6) == 0) req[b] = ~req[b];
      end
    end
    req = '0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
